config_chain_loader: RTL and testbench

//  Word-to-serial configuration loader feeding the sram select ports of the routing and LUT mux trees.

---
 rtl/config_chain_loader_pkg.sv | 14 +
 rtl/ccff_shift_chain.sv | 32 +++
 rtl/config_chain_loader.sv | 125 ++++++++++++
 tb/tb_config_chain_loader.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_chain_loader_pkg.sv
// Shared types and defaults for the configuration chain loader.
package config_chain_loader_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int DEF_CHAIN_LEN = 32;
   localparam int DEF_WORD_W    = 8;

endpackage

// File: rtl/ccff_shift_chain.sv
// Serial-in configuration chain. Bit 0 takes the serial input, each flop
// passes its value one position up per enabled clock, the top flop is the tail.
module ccff_shift_chain
   import config_chain_loader_pkg::*;
#(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
   input  logic                 prog_clk,
   input  logic                 pReset_n,
   input  logic                 shift_en,
   input  logic                 serial_in,
   output logic [CHAIN_LEN-1:0] par_next,
   output logic                 tail
);

   logic [CHAIN_LEN-1:0] chain_q, chain_d;

   // Chain value after one shift; exported so the commit can include the bit shifted on the same edge.
   always_comb begin
      par_next = {chain_q[CHAIN_LEN-2:0], serial_in};
      chain_d  = shift_en ? par_next : chain_q;
   end

   // Chain flops.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) chain_q <= '0;
      else           chain_q <= chain_d;
   end

   assign tail = chain_q[CHAIN_LEN-1];

endmodule

// File: rtl/config_chain_loader.sv
// Word-to-serial configuration loader with atomic commit to a shadow register.
//
//  state | meaning
//  IDLE  | waiting for start, nothing loaded since reset
//  LOAD  | cfg_ready high, waiting for the next bitstream word
//  SHIFT | serializing the held word into the chain, one bit per clock
//  DONE  | chain committed to sram, waiting for the next start
module config_chain_loader
   import config_chain_loader_pkg::*;
#(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int WORD_W    = DEF_WORD_W
) (
   input  logic                 prog_clk,
   input  logic                 pReset_n,
   input  logic                 start,
   input  logic [WORD_W-1:0]    cfg_data,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   output logic                 ccff_tail,
   output logic [CHAIN_LEN-1:0] sram,
   output logic                 config_busy,
   output logic                 config_done,
   output logic                 config_err
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int WB_W  = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
   localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [WB_W-1:0]      word_bit_q, word_bit_d;
   logic [WORD_W-1:0]    word_q, word_d;
   logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 shift_en;
   logic [CHAIN_LEN-1:0] chain_next;

   ccff_shift_chain #(.CHAIN_LEN(CHAIN_LEN)) u_chain (
      .prog_clk  (prog_clk),
      .pReset_n  (pReset_n),
      .shift_en  (shift_en),
      .serial_in (word_q[0]),
      .par_next  (chain_next),
      .tail      (ccff_tail)
   );

   // Next-state, counters, word serializer and commit.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      word_bit_d = word_bit_q;
      word_d     = word_q;
      shadow_d   = shadow_q;
      done_d     = done_q;
      err_d      = err_q;
      shift_en   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_LOAD;
               bit_cnt_d = '0;
               done_d    = 1'b0;
               err_d     = 1'b0;
            end else if (state_q == S_DONE) begin
               done_d = 1'b1;
            end
         end
         S_LOAD: begin
            if (start) err_d = 1'b1;
            if (cfg_valid) begin
               word_d     = cfg_data;
               word_bit_d = '0;
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (start) err_d = 1'b1;
            shift_en   = 1'b1;
            word_d     = word_q >> 1;
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            word_bit_d = word_bit_q + WB_W'(1);
            // Last bit ends the load even mid-word; leftover word bits are dropped.
            if (bit_cnt_q == LAST_BIT) begin
               state_d  = S_DONE;
               shadow_d = chain_next;
            end else if (word_bit_q == LAST_WBIT) begin
               state_d = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         word_bit_q <= '0;
         word_q     <= '0;
         shadow_q   <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         word_bit_q <= word_bit_d;
         word_q     <= word_d;
         shadow_q   <= shadow_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign cfg_ready   = (state_q == S_LOAD);
   assign config_busy = (state_q == S_LOAD) || (state_q == S_SHIFT);
   assign config_done = done_q;
   assign config_err  = err_q;
   assign sram        = shadow_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench for config_chain_loader: default 32/8 instance plus a 10/4 partial-word instance.
module tb_config_chain_loader;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   logic        start_a, valid_a, ready_a, tail_a, busy_a, done_a, err_a;
   logic [7:0]  data_a;
   logic [31:0] sram_a;
   logic        start_p, valid_p, ready_p, tail_p, busy_p, done_p, err_p;
   logic [3:0]  data_p;
   logic [9:0]  sram_p;

   logic [31:0] exp_q [$];
   logic [9:0]  expp_q [$];

   config_chain_loader u_dut (
      .prog_clk(clk), .pReset_n(rst_n), .start(start_a), .cfg_data(data_a),
      .cfg_valid(valid_a), .cfg_ready(ready_a), .ccff_tail(tail_a), .sram(sram_a),
      .config_busy(busy_a), .config_done(done_a), .config_err(err_a)
   );

   config_chain_loader #(.CHAIN_LEN(10), .WORD_W(4)) u_dut_p (
      .prog_clk(clk), .pReset_n(rst_n), .start(start_p), .cfg_data(data_p),
      .cfg_valid(valid_p), .cfg_ready(ready_p), .ccff_tail(tail_p), .sram(sram_p),
      .config_busy(busy_p), .config_done(done_p), .config_err(err_p)
   );

   // First bit shifted lands at the top index, last bit at index 0.
   function automatic logic [31:0] model_a(input logic [7:0] w [4]);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < 32; k++) r[31-k] = w[k/8][k%8];
      return r;
   endfunction

   task automatic pulse_start_a(output int se);
      start_a = 1'b1;
      @(negedge clk);
      se = cyc;
      start_a = 1'b0;
   endtask

   task automatic drive_words_a(input logic [7:0] w [4], input int stall, output bit to);
      int b;
      to = 1'b0;
      for (int i = 0; i < 4; i++) begin
         b = 0;
         while (ready_a !== 1'b1 && b < 200) begin @(negedge clk); b++; end
         if (b >= 200) begin to = 1'b1; return; end
         repeat (stall) @(negedge clk);
         data_a  = w[i];
         valid_a = 1'b1;
         @(negedge clk);
         valid_a = 1'b0;
      end
   endtask

   task automatic run_load_a(input logic [7:0] w [4], input int stall, output int lat, output bit to);
      int se, b;
      bit dto;
      pulse_start_a(se);
      drive_words_a(w, stall, dto);
      b = 0;
      while (done_a !== 1'b1 && b < 300) begin @(negedge clk); b++; end
      lat = cyc - se;
      to  = dto | (b >= 300);
   endtask

   task automatic test_reset();
      bit bad_a, bad_p;
      bad_a = 1'b0;
      bad_p = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         start_a = 1'($urandom_range(0, 1)); valid_a = 1'($urandom_range(0, 1)); data_a = 8'($urandom);
         start_p = 1'($urandom_range(0, 1)); valid_p = 1'($urandom_range(0, 1)); data_p = 4'($urandom);
         @(negedge clk);
         if ({sram_a, ready_a, busy_a, done_a, err_a, tail_a} !== 37'd0) bad_a = 1'b1;
         if ({sram_p, ready_p, busy_p, done_p, err_p, tail_p} !== 15'd0) bad_p = 1'b1;
      end
      n_tests++;
      if (bad_a) begin
         n_fail++;
         $display("FAIL reset_a: sram=%h rdy=%b busy=%b done=%b err=%b tail=%b, expected all 0",
                  sram_a, ready_a, busy_a, done_a, err_a, tail_a);
      end
      n_tests++;
      if (bad_p) begin
         n_fail++;
         $display("FAIL reset_p: sram=%h rdy=%b busy=%b done=%b err=%b tail=%b, expected all 0",
                  sram_p, ready_p, busy_p, done_p, err_p, tail_p);
      end
      start_a = 1'b0; valid_a = 1'b0; data_a = '0;
      start_p = 1'b0; valid_p = 1'b0; data_p = '0;
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({ready_a, busy_a, ready_p, busy_p} !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_after_reset: rdy/busy a=%b%b p=%b%b expected 0000", ready_a, busy_a, ready_p, busy_p);
      end
   endtask

   task automatic test_full_load();
      logic [7:0]  w [4];
      logic [31:0] old, e;
      int se, chg, b, lat;
      bit to;
      w = '{8'hA5, 8'h3C, 8'hF0, 8'h81};
      old = sram_a;
      exp_q.push_back(model_a(w));
      pulse_start_a(se);
      chg = -1;
      b = 0;
      fork
         drive_words_a(w, 0, to);
         begin
            while (done_a !== 1'b1 && b < 300) begin
               if (chg < 0 && sram_a !== old) chg = cyc - se;
               @(negedge clk);
               b++;
            end
         end
      join
      lat = cyc - se;
      n_tests++;
      if (to || b >= 300) begin n_fail++; $display("FAIL full_timeout: cycles=%0d, expected done within bound", b); end
      n_tests++;
      if (lat != 37) begin n_fail++; $display("FAIL full_latency: done in cycle %0d, expected 38", lat + 1); end
      n_tests++;
      if (chg != 36) begin n_fail++; $display("FAIL full_commit_edge: sram changed at %0d, expected 36", chg); end
      n_tests++;
      if (sram_a[31] !== 1'b1 || sram_a[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL full_mapping: sram[31]=%b sram[0]=%b, expected 1 1", sram_a[31], sram_a[0]);
      end
      e = exp_q.pop_front();
      n_tests++;
      if (sram_a !== e) begin n_fail++; $display("FAIL full_sram: got %h expected %h", sram_a, e); end
      n_tests++;
      if (busy_a !== 1'b0 || err_a !== 1'b0) begin
         n_fail++;
         $display("FAIL full_flags: busy=%b err=%b expected 0 0", busy_a, err_a);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0]  w [4];
      logic [31:0] e;
      int lat;
      bit to;
      w = '{8'hA5, 8'h3C, 8'hF0, 8'h81};
      exp_q.push_back(model_a(w));
      run_load_a(w, 5, lat, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL bp_timeout: got timeout, expected completion"); end
      n_tests++;
      if (lat != 57) begin n_fail++; $display("FAIL bp_latency: done in cycle %0d, expected 58", lat + 1); end
      e = exp_q.pop_front();
      n_tests++;
      if (sram_a !== e) begin n_fail++; $display("FAIL bp_sram: got %h expected %h", sram_a, e); end
   endtask

   task automatic test_partial_word();
      logic [3:0] w [3];
      logic [9:0] e;
      int se, b, lat;
      bit to;
      w = '{4'hF, 4'h0, 4'hE};
      expp_q.push_back(10'b1111_0000_01);
      // start with a junk word valid in IDLE: it must not be consumed
      start_p = 1'b1; valid_p = 1'b1; data_p = 4'h5;
      @(negedge clk);
      se = cyc;
      start_p = 1'b0; valid_p = 1'b0;
      to = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b = 0;
         while (ready_p !== 1'b1 && b < 100) begin @(negedge clk); b++; end
         if (b >= 100) to = 1'b1;
         data_p = w[i]; valid_p = 1'b1;
         @(negedge clk);
         valid_p = 1'b0;
      end
      b = 0;
      while (done_p !== 1'b1 && b < 100) begin @(negedge clk); b++; end
      lat = cyc - se;
      n_tests++;
      if (to || b >= 100) begin n_fail++; $display("FAIL part_timeout: got timeout, expected completion"); end
      n_tests++;
      if (lat != 14) begin n_fail++; $display("FAIL part_latency: done in cycle %0d, expected 15", lat + 1); end
      e = expp_q.pop_front();
      n_tests++;
      if (sram_p !== e) begin n_fail++; $display("FAIL part_sram: got %b expected %b", sram_p, e); end
   endtask

   task automatic test_start_err();
      logic [7:0]  w [4];
      logic [31:0] e;
      int se, b, lat;
      bit to, err_mid, busy_mid;
      w = '{8'h12, 8'h34, 8'h56, 8'h78};
      exp_q.push_back(model_a(w));
      pulse_start_a(se);
      b = 0;
      fork
         drive_words_a(w, 0, to);
         begin
            repeat (4) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            err_mid  = err_a;
            busy_mid = busy_a;
         end
      join
      while (done_a !== 1'b1 && b < 300) begin @(negedge clk); b++; end
      lat = cyc - se;
      n_tests++;
      if (err_mid !== 1'b1 || busy_mid !== 1'b1) begin
         n_fail++;
         $display("FAIL err_set: err=%b busy=%b expected 1 1", err_mid, busy_mid);
      end
      n_tests++;
      if (to || b >= 300 || lat != 37) begin
         n_fail++;
         $display("FAIL err_latency: done in cycle %0d to=%b, expected 38", lat + 1, to);
      end
      e = exp_q.pop_front();
      n_tests++;
      if (sram_a !== e) begin n_fail++; $display("FAIL err_sram: got %h expected %h", sram_a, e); end
      n_tests++;
      if (err_a !== 1'b1) begin n_fail++; $display("FAIL err_sticky: err=%b expected 1", err_a); end
      // restart from DONE clears both flags
      exp_q.push_back(model_a(w));
      pulse_start_a(se);
      n_tests++;
      if ({done_a, err_a, busy_a} !== 3'b001) begin
         n_fail++;
         $display("FAIL err_clear: done/err/busy=%b expected 001", {done_a, err_a, busy_a});
      end
      drive_words_a(w, 0, to);
      b = 0;
      while (done_a !== 1'b1 && b < 300) begin @(negedge clk); b++; end
      e = exp_q.pop_front();
      n_tests++;
      if (to || b >= 300 || sram_a !== e) begin
         n_fail++;
         $display("FAIL err_reload: got %h expected %h", sram_a, e);
      end
   endtask

   task automatic test_reload();
      logic [7:0]  wp [4];
      logic [7:0]  wz [4];
      logic [31:0] p, e;
      int se, chg, b, lat, rel, k, tail_bad;
      bit to, exp_tail;
      wp = '{8'h5A, 8'hC3, 8'h0F, 8'h96};
      wz = '{8'h00, 8'h00, 8'h00, 8'h00};
      p = model_a(wp);
      exp_q.push_back(p);
      run_load_a(wp, 0, lat, to);
      e = exp_q.pop_front();
      n_tests++;
      if (to || sram_a !== e) begin n_fail++; $display("FAIL reload_first: got %h expected %h", sram_a, e); end
      exp_q.push_back(32'h0);
      pulse_start_a(se);
      chg = -1;
      b = 0;
      tail_bad = 0;
      fork
         drive_words_a(wz, 0, to);
         begin
            while (done_a !== 1'b1 && b < 300) begin
               rel = cyc - se;
               if (chg < 0 && sram_a !== p) chg = rel;
               // shifts completed before cycle rel+1; every 9th cycle is a LOAD
               k = 0;
               for (int c = 2; c <= rel; c++) if ((c - 1) % 9 != 0) k++;
               exp_tail = (k < 32) ? p[31-k] : 1'b0;
               if (tail_a !== exp_tail) tail_bad++;
               @(negedge clk);
               b++;
            end
         end
      join
      n_tests++;
      if (to || b >= 300 || chg != 36) begin
         n_fail++;
         $display("FAIL reload_commit_edge: sram changed at %0d, expected 36", chg);
      end
      e = exp_q.pop_front();
      n_tests++;
      if (sram_a !== e) begin n_fail++; $display("FAIL reload_sram: got %h expected %h", sram_a, e); end
      n_tests++;
      if (tail_bad != 0) begin n_fail++; $display("FAIL reload_tail: %0d wrong tail samples, expected 0", tail_bad); end
   endtask

   task automatic test_reset_mid_shift();
      logic [7:0]  w [4];
      logic [31:0] e;
      int se, lat;
      bit to;
      w = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      exp_q.push_back(32'hFFFF_FFFF);
      run_load_a(w, 0, lat, to);
      e = exp_q.pop_front();
      n_tests++;
      if (to || sram_a !== e) begin n_fail++; $display("FAIL mid_preload: got %h expected %h", sram_a, e); end
      pulse_start_a(se);
      data_a = 8'h0F; valid_a = 1'b1;
      @(negedge clk);
      valid_a = 1'b0;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      n_tests++;
      if ({busy_a, err_a, tail_a} !== 3'b111) begin
         n_fail++;
         $display("FAIL mid_before_reset: busy/err/tail=%b expected 111", {busy_a, err_a, tail_a});
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({sram_a, ready_a, busy_a, done_a, err_a, tail_a} !== 37'd0) begin
         n_fail++;
         $display("FAIL mid_async_reset: sram=%h rdy=%b busy=%b done=%b err=%b tail=%b, expected all 0",
                  sram_a, ready_a, busy_a, done_a, err_a, tail_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      start_a = 1'b0; valid_a = 1'b0; data_a = '0;
      start_p = 1'b0; valid_p = 1'b0; data_p = '0;
      rst_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_full_load();
      test_backpressure();
      test_partial_word();
      test_start_err();
      test_reload();
      test_reset_mid_shift();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
